// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings for the pipeline hazard/forwarding controller.
//   - writeback select codes (WB_*) seen on WBSel_EX
//   - forwarding mux select codes (FWD_*) driven on FwdA_EX/FwdB_EX
//   - FSM state encoding
//   - src_hit(): "ID instruction reads this register" match helper
package pipe_ctrl_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_FLUSH    = 2'b10
  } hz_state_e;

  function automatic logic src_hit(input logic used, input logic [4:0] rs,
                                   input logic [4:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the pipeline datapath and the hazard
// controller.
//   master  - pipeline side: drives register ids/enables, receives controls
//   slave   - controller side: receives ids/enables, drives stall/flush/clear,
//             forward selects and the stall/flush performance counters
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1_ID;
  logic [4:0]       Rs2_ID;
  logic             Rs1Used_ID;
  logic             Rs2Used_ID;
  logic [4:0]       Rd_EX;
  logic             RegWEn_EX;
  logic [1:0]       WBSel_EX;
  logic             PCsel_EX;
  logic [4:0]       Rs1_EX;
  logic [4:0]       Rs2_EX;
  logic [4:0]       Rd_MEM;
  logic [4:0]       Rd_WB;
  logic             RegWEn_MEM;
  logic             RegWEn_WB;

  logic             Stall_IF;
  logic             Stall_ID;
  logic             Flush_ID;
  logic             Clear_EX;
  logic [1:0]       FwdA_EX;
  logic [1:0]       FwdB_EX;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs1_ID, Rs2_ID, Rs1Used_ID, Rs2Used_ID, Rd_EX, RegWEn_EX, WBSel_EX,
           PCsel_EX, Rs1_EX, Rs2_EX, Rd_MEM, Rd_WB, RegWEn_MEM, RegWEn_WB,
    input  Stall_IF, Stall_ID, Flush_ID, Clear_EX, FwdA_EX, FwdB_EX,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1_ID, Rs2_ID, Rs1Used_ID, Rs2Used_ID, Rd_EX, RegWEn_EX, WBSel_EX,
           PCsel_EX, Rs1_EX, Rs2_EX, Rd_MEM, Rd_WB, RegWEn_MEM, RegWEn_WB,
    output Stall_IF, Stall_ID, Flush_ID, Clear_EX, FwdA_EX, FwdB_EX,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// hazard_fwd_sel: combinational forwarding select for one EX ALU operand.
//   i_rs_ex              source register of the EX instruction
//   i_rd_mem, i_wen_mem  destination / write enable of the MEM instruction
//   i_rd_wb,  i_wen_wb   destination / write enable of the WB instruction
//   o_fwd                FWD_MEM, FWD_WB or FWD_NONE (MEM is the younger
//                        producer, so it wins over WB)
module hazard_fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_rs_ex,
  input  logic [4:0] i_rd_mem,
  input  logic       i_wen_mem,
  input  logic [4:0] i_rd_wb,
  input  logic       i_wen_wb,
  output logic [1:0] o_fwd
);

  logic w_hit_mem;
  logic w_hit_wb;

  // x0 is hardwired to zero, so a write to it never produces a value.
  assign w_hit_mem = i_wen_mem && (i_rd_mem != 5'd0) && (i_rd_mem == i_rs_ex);
  assign w_hit_wb  = i_wen_wb  && (i_rd_wb  != 5'd0) && (i_rd_wb  == i_rs_ex);

  always_comb begin
    o_fwd = FWD_NONE;
    if (w_hit_mem)     o_fwd = FWD_MEM;
    else if (w_hit_wb) o_fwd = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/clear generation and operand forwarding for
// the 5-stage RV32I pipeline.
//   clk   pipeline clock
//   rst   asynchronous active-low reset; all control outputs are 0 while low
//   hz    slave side of pipe_hazard_ctrl_if (ids/enables in, controls out)
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_RUN      | normal flow; detects redirect and load-use hazards
//   ST_LU_STALL | remaining load-use bubble cycles, hold IF/ID, clear ID/EX
//   ST_FLUSH    | remaining redirect flush cycles, zero IF/ID, clear ID/EX
//
// The 3-bit down-counter r_cnt holds the cycles left after the current one;
// the FSM leaves LU_STALL/FLUSH on the edge where r_cnt is 1.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  hz_state_e        r_state;
  hz_state_e        w_state_nxt;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_lu;
  logic       w_stall;
  logic       w_flush;
  logic       w_clear;
  logic       w_flush_evt;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_lu = hz.RegWEn_EX && (hz.WBSel_EX == WB_MEM) && (hz.Rd_EX != 5'd0) &&
                (src_hit(hz.Rs1Used_ID, hz.Rs1_ID, hz.Rd_EX) ||
                 src_hit(hz.Rs2Used_ID, hz.Rs2_ID, hz.Rd_EX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_flush     = 1'b0;
    w_clear     = 1'b0;
    w_flush_evt = 1'b0;
    case (r_state)
      ST_RUN: begin
        // Redirect wins: the instruction in ID is on the wrong path anyway.
        if (hz.PCsel_EX) begin
          w_flush     = 1'b1;
          w_clear     = 1'b1;
          w_flush_evt = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = FL_RELOAD;
          end
        end else if (w_lu) begin
          w_stall = 1'b1;
          w_clear = 1'b1;
          if (LOAD_LAT > 1) begin
            w_state_nxt = ST_LU_STALL;
            w_cnt_nxt   = LU_RELOAD;
          end
        end
      end
      ST_LU_STALL: begin
        w_stall = 1'b1;
        w_clear = 1'b1;
        if (r_cnt <= 3'd1) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_FLUSH: begin
        w_flush = 1'b1;
        w_clear = 1'b1;
        if (hz.PCsel_EX) begin
          w_flush_evt = 1'b1;
          w_cnt_nxt   = FL_RELOAD;
        end else if (r_cnt <= 3'd1) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Gating with rst makes the outputs drop the moment reset asserts, even
  // though the combinational hazard terms may still be active.
  assign hz.Stall_IF = rst & w_stall;
  assign hz.Stall_ID = rst & w_stall;
  assign hz.Flush_ID = rst & w_flush;
  assign hz.Clear_EX = rst & w_clear;

  hazard_fwd_sel u_fwd_a (
    .i_rs_ex   (hz.Rs1_EX),
    .i_rd_mem  (hz.Rd_MEM),
    .i_wen_mem (hz.RegWEn_MEM),
    .i_rd_wb   (hz.Rd_WB),
    .i_wen_wb  (hz.RegWEn_WB),
    .o_fwd     (w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_rs_ex   (hz.Rs2_EX),
    .i_rd_mem  (hz.Rd_MEM),
    .i_wen_mem (hz.RegWEn_MEM),
    .i_rd_wb   (hz.Rd_WB),
    .i_wen_wb  (hz.RegWEn_WB),
    .o_fwd     (w_fwd_b)
  );

  assign hz.FwdA_EX = rst ? w_fwd_a : FWD_NONE;
  assign hz.FwdB_EX = rst ? w_fwd_b : FWD_NONE;

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: the stimulus process drives inputs 1 time unit after the
// rising edge and queues the expected outputs; the monitor pops and compares
// on the falling edge. Two instances cover different parameter sets:
//   dut_a: LOAD_LAT=3, FLUSH_CYCLES=2, CNT_W=32
//   dut_b: LOAD_LAT=1, FLUSH_CYCLES=1, CNT_W=3 (small width to reach saturation)
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  typedef struct packed {
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd_ex;
    logic       wen_ex;
    logic [1:0] wbsel;
    logic       pcsel;
    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;
    logic [4:0] rd_mem;
    logic [4:0] rd_wb;
    logic       wen_mem;
    logic       wen_wb;
  } in_t;

  in_t in_a;
  in_t in_b;

  pipe_hazard_ctrl_if #(.CNT_W(32)) ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(3))  ifb ();

  assign ifa.Rs1_ID = in_a.rs1_id;   assign ifb.Rs1_ID = in_b.rs1_id;
  assign ifa.Rs2_ID = in_a.rs2_id;   assign ifb.Rs2_ID = in_b.rs2_id;
  assign ifa.Rs1Used_ID = in_a.rs1u; assign ifb.Rs1Used_ID = in_b.rs1u;
  assign ifa.Rs2Used_ID = in_a.rs2u; assign ifb.Rs2Used_ID = in_b.rs2u;
  assign ifa.Rd_EX = in_a.rd_ex;     assign ifb.Rd_EX = in_b.rd_ex;
  assign ifa.RegWEn_EX = in_a.wen_ex; assign ifb.RegWEn_EX = in_b.wen_ex;
  assign ifa.WBSel_EX = in_a.wbsel;  assign ifb.WBSel_EX = in_b.wbsel;
  assign ifa.PCsel_EX = in_a.pcsel;  assign ifb.PCsel_EX = in_b.pcsel;
  assign ifa.Rs1_EX = in_a.rs1_ex;   assign ifb.Rs1_EX = in_b.rs1_ex;
  assign ifa.Rs2_EX = in_a.rs2_ex;   assign ifb.Rs2_EX = in_b.rs2_ex;
  assign ifa.Rd_MEM = in_a.rd_mem;   assign ifb.Rd_MEM = in_b.rd_mem;
  assign ifa.Rd_WB = in_a.rd_wb;     assign ifb.Rd_WB = in_b.rd_wb;
  assign ifa.RegWEn_MEM = in_a.wen_mem; assign ifb.RegWEn_MEM = in_b.wen_mem;
  assign ifa.RegWEn_WB = in_a.wen_wb;   assign ifb.RegWEn_WB = in_b.wen_wb;

  pipe_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .hz  (ifa)
  );

  pipe_hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .hz  (ifb)
  );

  typedef struct {
    int          dut;
    string       name;
    logic        sif, sid, fid, cex;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic expect_o(input int d, input string nm,
                          input logic sif, input logic sid, input logic fid,
                          input logic cex, input logic [1:0] fa,
                          input logic [1:0] fb, input int sc, input int fc);
    exp_t e;
    e.dut = d; e.name = nm;
    e.sif = sif; e.sid = sid; e.fid = fid; e.cex = cex;
    e.fa = fa; e.fb = fb; e.sc = 32'(sc); e.fc = 32'(fc);
    q.push_back(e);
  endtask

  function automatic in_t idle();
    in_t v = '0;
    return v;
  endfunction

  // lw x5 in EX, add x6,x5,x1 in ID
  function automatic in_t ld_use();
    in_t v = '0;
    v.rd_ex = 5'd5; v.wen_ex = 1'b1; v.wbsel = WB_MEM;
    v.rs1_id = 5'd5; v.rs1u = 1'b1; v.rs2_id = 5'd1; v.rs2u = 1'b1;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.dut == 0) begin
        a.sif = ifa.Stall_IF; a.sid = ifa.Stall_ID; a.fid = ifa.Flush_ID;
        a.cex = ifa.Clear_EX; a.fa = ifa.FwdA_EX; a.fb = ifa.FwdB_EX;
        a.sc = ifa.stall_cnt; a.fc = ifa.flush_cnt;
      end else begin
        a.sif = ifb.Stall_IF; a.sid = ifb.Stall_ID; a.fid = ifb.Flush_ID;
        a.cex = ifb.Clear_EX; a.fa = ifb.FwdA_EX; a.fb = ifb.FwdB_EX;
        a.sc = 32'(ifb.stall_cnt); a.fc = 32'(ifb.flush_cnt);
      end
      n_tests++;
      if (a.sif !== e.sif || a.sid !== e.sid || a.fid !== e.fid ||
          a.cex !== e.cex || a.fa !== e.fa || a.fb !== e.fb ||
          a.sc !== e.sc || a.fc !== e.fc) begin
        n_fail++;
        $display("FAIL %s: got sif=%b sid=%b fid=%b cex=%b fa=%b fb=%b sc=%0d fc=%0d, want sif=%b sid=%b fid=%b cex=%b fa=%b fb=%b sc=%0d fc=%0d",
                 e.name, a.sif, a.sid, a.fid, a.cex, a.fa, a.fb, a.sc, a.fc,
                 e.sif, e.sid, e.fid, e.cex, e.fa, e.fb, e.sc, e.fc);
      end
    end
    // A redirect can never coincide with a stall: in RUN it wins over the
    // load-use, and in LU_STALL EX holds a bubble.
    if (ifa.Stall_ID && ifa.PCsel_EX) begin
      n_fail++;
      $display("FAIL pcsel_during_stall_a: got Stall_ID=1 with PCsel_EX=1, want no overlap");
    end
    if (ifb.Stall_ID && ifb.PCsel_EX) begin
      n_fail++;
      $display("FAIL pcsel_during_stall_b: got Stall_ID=1 with PCsel_EX=1, want no overlap");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t v;
    in_a = idle(); in_b = idle();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset: outputs stay 0 even with a live load-use and forwarding match.
    cyc();
    v = ld_use(); v.rd_mem = 5'd7; v.wen_mem = 1'b1; v.rs1_ex = 5'd7;
    in_a = v; in_b = v;
    expect_o(0, "reset_a", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 0, 0);
    expect_o(1, "reset_b", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 0, 0);
    cyc();
    in_a = idle(); in_b = idle();
    rst_a = 1'b1; rst_b = 1'b1;

    // B: load-use with LOAD_LAT=1 -> single bubble
    cyc(); in_b = ld_use();
    expect_o(1, "lu1_stall", 1, 1, 0, 1, FWD_NONE, FWD_NONE, 0, 0);
    cyc(); in_b = idle();
    expect_o(1, "lu1_run", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 1, 0);

    // A: load-use with LOAD_LAT=3 -> three bubbles, independent of lu after
    cyc(); in_a = ld_use();
    expect_o(0, "lu3_c1", 1, 1, 0, 1, FWD_NONE, FWD_NONE, 0, 0);
    cyc(); in_a = idle();
    expect_o(0, "lu3_c2", 1, 1, 0, 1, FWD_NONE, FWD_NONE, 1, 0);
    cyc();
    expect_o(0, "lu3_c3", 1, 1, 0, 1, FWD_NONE, FWD_NONE, 2, 0);
    cyc();
    expect_o(0, "lu3_run", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 0);

    // A: redirect together with load-use, FLUSH_CYCLES=2
    cyc(); v = ld_use(); v.pcsel = 1'b1; in_a = v;
    expect_o(0, "fl2_pc_lu", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 3, 0);
    cyc(); in_a = idle();
    expect_o(0, "fl2_c2", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 3, 1);
    cyc();
    expect_o(0, "fl2_run", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 1);

    // A: second redirect during FLUSH reloads the counter
    cyc(); v = idle(); v.pcsel = 1'b1; in_a = v;
    expect_o(0, "fl_re_c1", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 3, 1);
    cyc();
    expect_o(0, "fl_re_pc2", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 3, 2);
    cyc(); in_a = idle();
    expect_o(0, "fl_re_c3", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 3, 3);
    cyc();
    expect_o(0, "fl_re_run", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 3);

    // B: redirect with load-use, FLUSH_CYCLES=1 -> single flush cycle
    cyc(); v = ld_use(); v.pcsel = 1'b1; in_b = v;
    expect_o(1, "fl1_pc_lu", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 1, 0);
    cyc(); in_b = idle();
    expect_o(1, "fl1_run", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 1, 1);

    // A: forwarding vectors
    cyc(); v = idle();
    v.rd_mem = 5'd7; v.rd_wb = 5'd7; v.wen_mem = 1'b1; v.wen_wb = 1'b1;
    v.rs1_ex = 5'd7; v.rs2_ex = 5'd3; in_a = v;
    expect_o(0, "fwd_mem_prio", 0, 0, 0, 0, FWD_MEM, FWD_NONE, 3, 3);
    cyc(); v.wen_mem = 1'b0; in_a = v;
    expect_o(0, "fwd_wb", 0, 0, 0, 0, FWD_WB, FWD_NONE, 3, 3);
    cyc(); v.wen_mem = 1'b1; v.rd_mem = 5'd0; v.rd_wb = 5'd0;
    v.rs1_ex = 5'd0; v.rs2_ex = 5'd0; in_a = v;
    expect_o(0, "fwd_x0", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 3, 3);
    cyc(); v = idle();
    v.rd_mem = 5'd3; v.wen_mem = 1'b1; v.rd_wb = 5'd9; v.wen_wb = 1'b1;
    v.rs1_ex = 5'd9; v.rs2_ex = 5'd3; in_a = v;
    expect_o(0, "fwd_b_mem_a_wb", 0, 0, 0, 0, FWD_WB, FWD_MEM, 3, 3);
    cyc(); v.rd_wb = 5'd3; v.rs1_ex = 5'd4; in_a = v;
    expect_o(0, "fwd_b_prio", 0, 0, 0, 0, FWD_NONE, FWD_MEM, 3, 3);
    cyc(); in_a = idle();

    // B: load to x0 and a non-load producer never stall
    cyc(); v = ld_use(); v.rd_ex = 5'd0; v.rs1_id = 5'd0; in_b = v;
    expect_o(1, "lu_x0", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 1, 1);
    cyc(); v = ld_use(); v.wbsel = WB_ALU; in_b = v;
    expect_o(1, "alu_no_lu", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 1, 1);
    cyc(); v = ld_use(); v.rs1u = 1'b0; in_b = v;
    expect_o(1, "rs1_unused", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 1, 1);

    // B: 3-bit stall counter saturates at 7
    for (int i = 0; i < 8; i++) begin
      cyc(); in_b = ld_use();
      expect_o(1, $sformatf("sat_%0d", i), 1, 1, 0, 1, FWD_NONE, FWD_NONE,
               (1 + i > 7) ? 7 : 1 + i, 1);
    end
    cyc(); in_b = idle();
    expect_o(1, "sat_hold", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 7, 1);

    // A: reset asserted in the middle of LU_STALL
    cyc(); in_a = ld_use();
    expect_o(0, "rst_mid_c1", 1, 1, 0, 1, FWD_NONE, FWD_NONE, 3, 3);
    cyc(); rst_a = 1'b0;
    expect_o(0, "rst_mid_drop", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 0, 0);
    cyc(); rst_a = 1'b1; in_a = idle();
    expect_o(0, "rst_release", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 0, 0);
    // A redirect is only honoured from RUN, proving the FSM restarted there.
    cyc(); v = idle(); v.pcsel = 1'b1; in_a = v;
    expect_o(0, "rst_run_pc", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 0, 0);
    cyc(); in_a = idle();
    expect_o(0, "rst_run_fl2", 0, 0, 1, 1, FWD_NONE, FWD_NONE, 0, 1);
    cyc();
    expect_o(0, "rst_run_end", 0, 0, 0, 0, FWD_NONE, FWD_NONE, 0, 1);

    cyc();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and forwarding controller for the 5-stage RV32I pipeline. It generates the stall, flush and clear controls that drive the IF/ID and ID/EX pipeline registers, and the operand-forwarding selects used by the EX-stage ALU muxes. A small FSM handles multi-cycle load-use bubbles and multi-cycle redirect flushes. Saturating counters record stall and flush events for performance analysis.

Parameters:
LOAD_LAT, 1, number of bubble cycles inserted on a load-use hazard (1..7)
FLUSH_CYCLES, 1, number of cycles Flush_ID stays asserted after a taken redirect (1..7)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
Rs1_ID, Rs2_ID  in  5  source registers of the instruction in ID
Rs1Used_ID, Rs2Used_ID  in  1  instruction in ID actually reads rs1/rs2
Rd_EX  in  5  destination register in EX
RegWEn_EX  in  1  EX instruction writes the register file
WBSel_EX  in  2  EX writeback select (WB_MEM marks a load)
PCsel_EX  in  1  redirect (taken branch or jump) resolved in EX
Rs1_EX, Rs2_EX  in  5  source registers in EX
Rd_MEM, Rd_WB  in  5  destination registers in MEM/WB
RegWEn_MEM, RegWEn_WB  in  1  register write enables in MEM/WB
Stall_IF  out  1  hold PC
Stall_ID  out  1  hold IF/ID register
Flush_ID  out  1  zero IF/ID register
Clear_EX  out  1  drives the clear input of the ID/EX register
FwdA_EX, FwdB_EX  out  2  ALU operand A/B forward select
stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- Reset (rst=0, asynchronous): state RUN, counter 0, stall_cnt=flush_cnt=0. Every control output is 0 while rst=0.
- Load-use hazard (lu) = RegWEn_EX && WBSel_EX==WB_MEM && Rd_EX!=0 && ((Rs1Used_ID && Rs1_ID==Rd_EX) || (Rs2Used_ID && Rs2_ID==Rd_EX)).
- FSM states: RUN, LU_STALL, FLUSH. A down-counter of 3 bits is shared by LU_STALL and FLUSH.
- RUN, PCsel_EX=1: Flush_ID=1 and Clear_EX=1 in the same cycle; flush_cnt increments once. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
- Priority: PCsel_EX beats lu, because the instruction in ID is wrong-path.
- RUN, lu=1 and PCsel_EX=0: Stall_IF=Stall_ID=1 and Clear_EX=1 in the same cycle. If LOAD_LAT>1, go to LU_STALL with counter=LOAD_LAT-1.
- LU_STALL: Stall_IF=Stall_ID=Clear_EX=1 regardless of lu. The counter decrements each cycle; when the counter is 1, return to RUN on the next edge. PCsel_EX=1 here is illegal (EX holds a bubble) and is covered by a bench assertion.
- FLUSH: Flush_ID=1 and Clear_EX=1. The counter decrements; return to RUN when it reaches 1. A new PCsel_EX in FLUSH reloads the counter and increments flush_cnt.
- Forwarding for operand A (operand B is symmetric, using Rs2_EX):
  - FWD_MEM (2'b01) if RegWEn_MEM && Rd_MEM!=0 && Rd_MEM==Rs1_EX.
  - Otherwise FWD_WB (2'b10) if the same condition holds for WB.
  - Otherwise FWD_NONE (2'b00).
  - MEM has priority over WB. The forwarding path is purely combinational.
- stall_cnt increments on every cycle with Stall_ID=1. Both counters saturate at all-ones and do not wrap.
- All control outputs are combinational from the current state and inputs. The only registered elements are the state, the counter and the perf counters.
- Reset asserted mid-stall or mid-flush: the FSM returns to RUN immediately and the outputs drop to 0 asynchronously.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10;
  - FWD_NONE/FWD_MEM/FWD_WB;
  - the FSM state encoding.
- Sub-module hazard_fwd_sel is the combinational forwarding comparator for one operand. It is instantiated twice, once for A and once for B.

Test Plan:
- Load x5, then add x6,x5,x1 in ID (LOAD_LAT=1) -> one cycle of Stall_IF=Stall_ID=Clear_EX=1, then RUN; stall_cnt=1.
- Same sequence with LOAD_LAT=3 -> exactly 3 consecutive stall cycles; stall_cnt=3.
- PCsel_EX=1 together with lu=1 in the same cycle -> Flush_ID=Clear_EX=1, Stall_ID=0; flush_cnt=1. With FLUSH_CYCLES=2, Flush_ID stays high for 2 cycles.
- Rd_MEM=Rd_WB=7, both RegWEn=1, Rs1_EX=7 -> FwdA_EX=2'b01. Set RegWEn_MEM=0 -> 2'b10. Set Rd=0 -> 2'b00.
- Load to x0 with Rs1_ID=0 -> no stall.
- Preload stall_cnt near all-ones and force stalls -> the counter holds at all-ones.
- Drive rst=0 in the middle of LU_STALL with LOAD_LAT=3 -> outputs drop to 0 immediately; after release, state is RUN and the counters read 0.
